clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Sequencer that owns the configuration of an integer clock divider (WIDTH-bit ratio, 50 % duty, even/odd). It accepts ratio-change requests over a valid/ready handshake and validates them. For each accepted change it:

- waits for the divided clock to be low,
- gates it off,
- holds the divider in reset while loading the new ratio,
- releases the divider and lets it settle,
- then re-enables the gated output and reports lock.

It sits between the register/CSR logic and the divider instance. The divider's reset, ratio input and the downstream clock gate are driven only by this block.

## Interface
- WIDTH, 3: divider ratio width.
- DEFAULT_RATIO, 2: ratio applied at bring-up after reset; must be ≥ 2.
- HOLD_CYCLES, 2: cycles the divider is held in reset; must be ≥ 1.
- TIMEOUT, 64: DRAIN timeout in cycles; used only with the timeout macro.
- clock  in  1: reference clock (also the divider's input clock).
- reset_n  in  1: asynchronous, active-low reset.
- req_valid  in  1: new-ratio request.
- req_ratio  in  WIDTH: requested ratio.
- req_ready  out  1: request can be accepted.
- clk_fb  in  1: divided clock fed back from the divider output.
- div_ratio  out  WIDTH: ratio to the divider.
- div_rst_n  out  1: active-low reset to the divider.
- clk_en  out  1: enable for the downstream clock gate.
- locked  out  1: divider stable at div_ratio and gate open.
- done  out  1: one-cycle pulse when locked rises.
- req_err  out  1: one-cycle pulse on a rejected request or a DRAIN timeout.

## Operation
- All outputs are registered.
- Reset values: req_ready=0, div_ratio=DEFAULT_RATIO, div_rst_n=0, clk_en=0, locked=0, done=0, req_err=0. The state machine resets into HOLD, so bring-up runs automatically.
- clk_fb passes through a 2-flop synchronizer to produce fb_s.
- States and transitions:
  - LOCKED: req_ready=1, locked=1, clk_en=1, div_rst_n=1.
    - Handshake completes when req_valid && req_ready.
    - req_ratio < 2: request rejected. req_err pulses, state stays LOCKED, div_ratio unchanged.
    - req_ratio == div_ratio: accepted; done pulses and state stays LOCKED.
    - Otherwise: the ratio is captured into a pending register → DRAIN.
  - DRAIN: req_ready=0, locked=0, gate still open. Waits for fb_s==0 → HOLD.
  - HOLD: clk_en=0, div_rst_n=0. On entry, div_ratio is loaded from the pending register. A counter runs HOLD_CYCLES cycles → SETTLE.
  - SETTLE: div_rst_n=1, clk_en=0. A (WIDTH+1)-bit counter runs 2*div_ratio cycles, i.e. two full divided periods → LOCKED.
    - On entry to LOCKED, clk_en=1, locked=1 and done pulses.
- In every state other than LOCKED, req_ready=0 and requests are ignored; no queueing.
- Reset asserted mid-sequence: all outputs return to their reset values immediately. The pending ratio is discarded and bring-up restarts with DEFAULT_RATIO.
- Arithmetic: the settle count is compared against {div_ratio,1'b0} at WIDTH+1 bits, so the maximum ratio 2^WIDTH−1 does not overflow.

## Timing
- Accept at edge k → locked=0, state DRAIN at k+1.
- DRAIN exit occurs one cycle after fb_s==0 is seen. Because of the synchronizer, fb_s lags clk_fb by 2 cycles.
- HOLD lasts exactly HOLD_CYCLES cycles; div_ratio changes on the first HOLD edge.
- SETTLE lasts exactly 2*ratio cycles; clk_en, locked and done rise on the same edge.
- Bring-up after reset release: HOLD_CYCLES + 2*DEFAULT_RATIO cycles until locked (default 2+4 = 6).
- done and req_err are exactly one cycle wide.

## Configuration
- CLK_DIV_CTRL_TIMEOUT_EN defined:
  - DRAIN counts cycles. If fb_s is still high after TIMEOUT cycles, req_err pulses and the FSM forces HOLD anyway.
- Not defined:
  - DRAIN waits indefinitely for fb_s==0.
  - No timeout counter is built, and req_err comes only from rejected ratios.

## Structure
- Package clk_div_pkg holds:
  - the state encoding (LOCKED, DRAIN, HOLD, SETTLE),
  - the minimum-ratio constant (2),
  - the default parameter constants.
- Sub-module clk_div_sync: 2-flop synchronizer with async active-low reset, reset value 0, used for clk_fb.

## Test plan
- Reset release with DEFAULT_RATIO=2, HOLD_CYCLES=2 → locked and done rise 6 cycles after reset release; div_ratio=2; clk_en=1.
- From LOCKED, request ratio 5 with clk_fb high for 3 cycles → DRAIN holds until fb_s low. Then div_rst_n is low for 2 cycles with div_ratio=5, SETTLE runs 10 cycles, locked returns and done pulses once.
- Request ratio 1, then ratio 0 → req_err pulses each time; div_ratio, locked and req_ready unchanged.
- Request ratio equal to the current ratio (2) → done pulses on the next cycle; locked never drops; div_rst_n stays 1.
- Assert reset_n during SETTLE of a change to 7 → outputs go to their reset values asynchronously; after release the sequence completes at ratio 2, not 7.
- With CLK_DIV_CTRL_TIMEOUT_EN, TIMEOUT=64, hold clk_fb=1 → req_err pulses after 64 DRAIN cycles, then the HOLD/SETTLE sequence completes normally.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider configuration sequencer:
// FSM state encoding, the minimum legal ratio and default parameter values.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_LOCKED = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    localparam int MIN_RATIO         = 2;
    localparam int DEF_WIDTH         = 3;
    localparam int DEF_DEFAULT_RATIO = 2;
    localparam int DEF_HOLD_CYCLES   = 2;
    localparam int DEF_TIMEOUT       = 64;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_div_sync.sv
// Two-flop synchronizer for the divided-clock feedback; clears to 0 on reset.
module clk_div_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 1'b0;
            q        <= 1'b0;
        end else begin
            meta_reg <= d;
            q        <= meta_reg;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Ratio-change sequencer for an integer clock divider: drain, hold in reset, settle, relock.
// Optional DRAIN timeout is built when CLK_DIV_CTRL_TIMEOUT_EN is defined.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int DEFAULT_RATIO = DEF_DEFAULT_RATIO,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_ratio,
    output logic             req_ready,
    input  logic             clk_fb,
    output logic [WIDTH-1:0] div_ratio,
    output logic             div_rst_n,
    output logic             clk_en,
    output logic             locked,
    output logic             done,
    output logic             req_err
);

    localparam int                HOLD_W    = cnt_width(HOLD_CYCLES);
    localparam int                SETTLE_W  = WIDTH + 1;
    localparam logic [WIDTH-1:0]  RATIO_RST = WIDTH'(DEFAULT_RATIO);
    localparam logic [WIDTH-1:0]  RATIO_MIN = WIDTH'(MIN_RATIO);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

    state_t              state_reg, state_next;
    logic [WIDTH-1:0]    pending_reg, pending_next;
    logic [WIDTH-1:0]    ratio_reg, ratio_next;
    logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next, hold_inc;
    logic [SETTLE_W-1:0] settle_cnt_reg, settle_cnt_next, settle_inc;
    logic                ready_reg, ready_next;
    logic                rst_n_reg, rst_n_next;
    logic                en_reg, en_next;
    logic                locked_reg, locked_next;
    logic                done_reg, done_next;
    logic                err_reg, err_next;
    logic                fb_s;
    logic                drain_timeout;

    clk_div_sync u_fb_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (clk_fb),
        .q       (fb_s)
    );

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    localparam int                 DRAIN_W    = cnt_width(TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(TIMEOUT);

    logic [DRAIN_W-1:0] drain_cnt_reg, drain_cnt_next;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt_reg <= '0;
        end else begin
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Counter is parked at zero outside DRAIN so each drain starts fresh.
    always_comb begin
        drain_cnt_next = '0;
        drain_timeout  = 1'b0;
        if (state_reg == ST_DRAIN) begin
            drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
            drain_timeout  = fb_s && (drain_cnt_next == DRAIN_LAST);
        end
    end
`else
    assign drain_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_HOLD;
            pending_reg    <= RATIO_RST;
            ratio_reg      <= RATIO_RST;
            hold_cnt_reg   <= '0;
            settle_cnt_reg <= '0;
            ready_reg      <= 1'b0;
            rst_n_reg      <= 1'b0;
            en_reg         <= 1'b0;
            locked_reg     <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pending_reg    <= pending_next;
            ratio_reg      <= ratio_next;
            hold_cnt_reg   <= hold_cnt_next;
            settle_cnt_reg <= settle_cnt_next;
            ready_reg      <= ready_next;
            rst_n_reg      <= rst_n_next;
            en_reg         <= en_next;
            locked_reg     <= locked_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    // Outputs are computed one cycle ahead so that every port comes from a flop.
    always_comb begin
        state_next      = state_reg;
        pending_next    = pending_reg;
        ratio_next      = ratio_reg;
        hold_cnt_next   = '0;
        settle_cnt_next = '0;
        ready_next      = ready_reg;
        rst_n_next      = rst_n_reg;
        en_next         = en_reg;
        locked_next     = locked_reg;
        done_next       = 1'b0;
        err_next        = 1'b0;
        hold_inc        = hold_cnt_reg + HOLD_W'(1);
        settle_inc      = settle_cnt_reg + SETTLE_W'(1);

        case (state_reg)
            ST_LOCKED: begin
                if (req_valid && ready_reg) begin
                    if (req_ratio < RATIO_MIN) begin
                        err_next = 1'b1;
                    end else if (req_ratio == ratio_reg) begin
                        done_next = 1'b1;
                    end else begin
                        pending_next = req_ratio;
                        state_next   = ST_DRAIN;
                        ready_next   = 1'b0;
                        locked_next  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                // Only gate the clock while it is low to avoid a runt pulse.
                if (!fb_s || drain_timeout) begin
                    err_next   = drain_timeout;
                    state_next = ST_HOLD;
                    ratio_next = pending_reg;
                    rst_n_next = 1'b0;
                    en_next    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (hold_inc == HOLD_LAST) begin
                    state_next = ST_SETTLE;
                    rst_n_next = 1'b1;
                end else begin
                    hold_cnt_next = hold_inc;
                end
            end
            ST_SETTLE: begin
                // Two full divided periods; compared at WIDTH+1 bits so max ratio cannot wrap.
                if (settle_inc == {ratio_reg, 1'b0}) begin
                    state_next  = ST_LOCKED;
                    en_next     = 1'b1;
                    locked_next = 1'b1;
                    done_next   = 1'b1;
                    ready_next  = 1'b1;
                end else begin
                    settle_cnt_next = settle_inc;
                end
            end
            default: begin
                state_next = ST_HOLD;
            end
        endcase
    end

    assign req_ready = ready_reg;
    assign div_ratio = ratio_reg;
    assign div_rst_n = rst_n_reg;
    assign clk_en    = en_reg;
    assign locked    = locked_reg;
    assign done      = done_reg;
    assign req_err   = err_reg;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: scoreboard of expected done/req_err pulses plus
// per-scenario state checks. Timeout scenario runs when CLK_DIV_CTRL_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_ratio = 3'd0;
    logic       clk_fb    = 1'b0;
    logic       req_ready;
    logic [2:0] div_ratio;
    logic       div_rst_n;
    logic       clk_en;
    logic       locked;
    logic       done;
    logic       req_err;

    clk_div_ctrl #(
        .WIDTH         (3),
        .DEFAULT_RATIO (2),
        .HOLD_CYCLES   (2),
        .TIMEOUT       (64)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ratio (req_ratio),
        .req_ready (req_ready),
        .clk_fb    (clk_fb),
        .div_ratio (div_ratio),
        .div_rst_n (div_rst_n),
        .clk_en    (clk_en),
        .locked    (locked),
        .done      (done),
        .req_err   (req_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       is_done;
        logic       is_err;
        logic [2:0] ratio;
        int         cyc;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;

    task automatic expect_event(input logic d, input logic e, input logic [2:0] r, input int at);
        ev_t ev;
        ev.is_done = d;
        ev.is_err  = e;
        ev.ratio   = r;
        ev.cyc     = at;
        exp_q.push_back(ev);
    endtask

    // Advance to the next falling edge and score any done/req_err pulse seen there.
    task automatic tick();
        ev_t ev;
        @(negedge clock);
        cyc++;
        if (reset_n && (done === 1'b1 || req_err === 1'b1)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected: cyc=%0d done=%b req_err=%b div_ratio=%0d, required no event",
                         cyc, done, req_err, div_ratio);
            end else begin
                ev = exp_q.pop_front();
                if (done !== ev.is_done || req_err !== ev.is_err || div_ratio !== ev.ratio || cyc != ev.cyc) begin
                    errors++;
                    $display("FAIL scoreboard_event: got cyc=%0d done=%b req_err=%b ratio=%0d, required cyc=%0d done=%b req_err=%b ratio=%0d",
                             cyc, done, req_err, div_ratio, ev.cyc, ev.is_done, ev.is_err, ev.ratio);
                end else begin
                    $display("event cyc=%0d done=%b req_err=%b div_ratio=%0d matched", cyc, done, req_err, div_ratio);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({req_ready, div_ratio, div_rst_n, clk_en, locked, done, req_err} !== 9'b0_010_00000) begin
            errors++;
            $display("FAIL reset_values: got %b required %b",
                     {req_ready, div_ratio, div_rst_n, clk_en, locked, done, req_err}, 9'b0_010_00000);
        end
        reset_n = 1'b1;
        expect_event(1'b1, 1'b0, 3'd2, cyc + 6);
        repeat (5) tick();
        checks++;
        if (locked !== 1'b0 || div_rst_n !== 1'b1 || clk_en !== 1'b0) begin
            errors++;
            $display("FAIL bringup_settle: got locked=%b div_rst_n=%b clk_en=%b, required 0 1 0",
                     locked, div_rst_n, clk_en);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || clk_en !== 1'b1 || req_ready !== 1'b1 || div_ratio !== 3'd2) begin
            errors++;
            $display("FAIL bringup_lock: got locked=%b clk_en=%b req_ready=%b ratio=%0d, required 1 1 1 2",
                     locked, clk_en, req_ready, div_ratio);
        end
        $display("reset bring-up: locked=%b at cyc %0d", locked, cyc);
    endtask

    task automatic test_reject();
        logic [2:0] bad [2] = '{3'd1, 3'd0};
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1;
            req_ratio = bad[i];
            expect_event(1'b0, 1'b1, 3'd2, cyc + 1);
            tick();
            req_valid = 1'b0;
            checks++;
            if (div_ratio !== 3'd2 || locked !== 1'b1 || req_ready !== 1'b1 || div_rst_n !== 1'b1) begin
                errors++;
                $display("FAIL reject_state: ratio_req=%0d got ratio=%0d locked=%b ready=%b div_rst_n=%b, required 2 1 1 1",
                         bad[i], div_ratio, locked, req_ready, div_rst_n);
            end
            tick();
            checks++;
            if (req_err !== 1'b0) begin
                errors++;
                $display("FAIL reject_pulse_width: got req_err=%b required 0", req_err);
            end
        end
    endtask

    task automatic test_equal();
        req_valid = 1'b1;
        req_ratio = 3'd2;
        expect_event(1'b1, 1'b0, 3'd2, cyc + 1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (locked !== 1'b1 || div_rst_n !== 1'b1 || clk_en !== 1'b1) begin
                errors++;
                $display("FAIL equal_no_drop: got locked=%b div_rst_n=%b clk_en=%b, required 1 1 1",
                         locked, div_rst_n, clk_en);
            end
            tick();
        end
    endtask

    task automatic test_change();
        int f;
        clk_fb = 1'b1;
        tick();
        tick();
        req_valid = 1'b1;
        req_ratio = 3'd5;
        tick();
        req_valid = 1'b0;
        clk_fb    = 1'b0;
        f         = cyc;
        expect_event(1'b1, 1'b0, 3'd5, f + 15);
        checks++;
        if (locked !== 1'b0 || req_ready !== 1'b0 || clk_en !== 1'b1 || div_rst_n !== 1'b1 || div_ratio !== 3'd2) begin
            errors++;
            $display("FAIL change_accept: got locked=%b ready=%b clk_en=%b div_rst_n=%b ratio=%0d, required 0 0 1 1 2",
                     locked, req_ready, clk_en, div_rst_n, div_ratio);
        end
        tick();
        tick();
        checks++;
        if (div_rst_n !== 1'b1 || clk_en !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL change_drain_wait: got div_rst_n=%b clk_en=%b locked=%b, required 1 1 0",
                     div_rst_n, clk_en, locked);
        end
        tick();
        checks++;
        if (div_rst_n !== 1'b0 || clk_en !== 1'b0 || div_ratio !== 3'd5) begin
            errors++;
            $display("FAIL change_hold_entry: got div_rst_n=%b clk_en=%b ratio=%0d, required 0 0 5",
                     div_rst_n, clk_en, div_ratio);
        end
        tick();
        checks++;
        if (div_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL change_hold_len: got div_rst_n=%b required 0", div_rst_n);
        end
        tick();
        checks++;
        if (div_rst_n !== 1'b1 || clk_en !== 1'b0) begin
            errors++;
            $display("FAIL change_settle_entry: got div_rst_n=%b clk_en=%b, required 1 0", div_rst_n, clk_en);
        end
        repeat (9) tick();
        checks++;
        if (locked !== 1'b0 || clk_en !== 1'b0) begin
            errors++;
            $display("FAIL change_settle_len: got locked=%b clk_en=%b, required 0 0", locked, clk_en);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || clk_en !== 1'b1 || req_ready !== 1'b1 || div_ratio !== 3'd5) begin
            errors++;
            $display("FAIL change_relock: got locked=%b clk_en=%b ready=%b ratio=%0d, required 1 1 1 5",
                     locked, clk_en, req_ready, div_ratio);
        end
    endtask

    task automatic test_back_to_back();
        expect_event(1'b1, 1'b0, 3'd3, cyc + 10);
        req_valid = 1'b1;
        req_ratio = 3'd3;
        tick();
        req_ratio = 3'd4;
        repeat (5) tick();
        req_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (locked !== 1'b1 || div_ratio !== 3'd3) begin
            errors++;
            $display("FAIL back_to_back_ignored: got locked=%b ratio=%0d, required 1 3", locked, div_ratio);
        end
        tick();
    endtask

`ifdef CLK_DIV_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        clk_fb = 1'b1;
        tick();
        tick();
        c = cyc;
        expect_event(1'b0, 1'b1, 3'd6, c + 65);
        expect_event(1'b1, 1'b0, 3'd6, c + 79);
        req_valid = 1'b1;
        req_ratio = 3'd6;
        tick();
        req_valid = 1'b0;
        repeat (63) tick();
        checks++;
        if (div_rst_n !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drain_wait: got div_rst_n=%b locked=%b, required 1 0", div_rst_n, locked);
        end
        tick();
        clk_fb = 1'b0;
        checks++;
        if (div_rst_n !== 1'b0 || div_ratio !== 3'd6) begin
            errors++;
            $display("FAIL timeout_forced_hold: got div_rst_n=%b ratio=%0d, required 0 6", div_rst_n, div_ratio);
        end
        repeat (14) tick();
        checks++;
        if (locked !== 1'b1 || div_ratio !== 3'd6) begin
            errors++;
            $display("FAIL timeout_relock: got locked=%b ratio=%0d, required 1 6", locked, div_ratio);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        req_valid = 1'b1;
        req_ratio = 3'd7;
        tick();
        req_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (div_ratio !== 3'd7 || div_rst_n !== 1'b1 || clk_en !== 1'b0) begin
            errors++;
            $display("FAIL midreset_in_settle: got ratio=%0d div_rst_n=%b clk_en=%b, required 7 1 0",
                     div_ratio, div_rst_n, clk_en);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, div_ratio, div_rst_n, clk_en, locked, done, req_err} !== 9'b0_010_00000) begin
            errors++;
            $display("FAIL midreset_async: got %b required %b",
                     {req_ready, div_ratio, div_rst_n, clk_en, locked, done, req_err}, 9'b0_010_00000);
        end
        repeat (2) tick();
        reset_n = 1'b1;
        expect_event(1'b1, 1'b0, 3'd2, cyc + 6);
        n = 0;
        while (locked !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (locked !== 1'b1 || div_ratio !== 3'd2 || n != 6) begin
            errors++;
            $display("FAIL midreset_relock: got locked=%b ratio=%0d after %0d cycles, required 1 2 after 6",
                     locked, div_ratio, n);
        end
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_reject();
        test_equal();
        test_change();
        test_back_to_back();
`ifdef CLK_DIV_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending events, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
